// File: rtl/v4l2_call_pkg.sv
// Shared types for the v4l2_ctrl_get_name caller slice.
// Default widths mirror the component's id and returndata ports.
package v4l2_call_pkg;

    localparam int DEF_ID_W  = 32;
    localparam int DEF_RET_W = 64;

    typedef struct packed {
        logic [DEF_ID_W-1:0]  id;
        logic [DEF_RET_W-1:0] name;
    } rsp_t;

    typedef enum logic {
        IDLE  = 1'b0,
        ISSUE = 1'b1
    } state_e;

endpackage

// File: rtl/v4l2_sync_fifo.sv
// Single-clock FIFO with occupancy count; push when full and pop
// when empty are ignored so callers can never corrupt the pointers.
module v4l2_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 2,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             full,
    output logic             empty,
    output logic [AW:0]      count
);

    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      count_q, count_d;
    logic             push_en;
    logic             pop_en;

    assign full     = (count_q == FULL_CNT);
    assign empty    = (count_q == '0);
    assign count    = count_q;
    assign pop_data = mem_q[rd_ptr_q];
    assign push_en  = push && !full;
    assign pop_en   = pop && !empty;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_en) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (pop_en) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        unique case ({push_en, pop_en})
            2'b10:   count_d = count_q + (AW+1)'(1);
            2'b01:   count_d = count_q - (AW+1)'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: contents are only observed behind count.
    always_ff @(posedge clock) begin
        if (push_en) begin
            mem_q[wr_ptr_q] <= push_data;
        end
    end

endmodule

// File: rtl/v4l2_ctrl_name_caller.sv
// Call/return initiator for v4l2_ctrl_get_name: issues control IDs,
// tracks them in a tag FIFO and emits in-order {id, name} responses.
module v4l2_ctrl_name_caller
    import v4l2_call_pkg::*;
#(
    parameter int ID_W            = DEF_ID_W,
    parameter int RET_W           = DEF_RET_W,
    parameter int MAX_OUTSTANDING = 4,
    parameter int RSP_DEPTH       = 2,
    localparam int OW             = $clog2(MAX_OUTSTANDING) + 1,
    localparam int RW             = $clog2(RSP_DEPTH) + 1
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [ID_W-1:0]  req_id,
    output logic             call_start,
    input  logic             call_busy,
    output logic [ID_W-1:0]  call_id,
    input  logic             ret_done,
    output logic             ret_stall,
    input  logic [RET_W-1:0] ret_data,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [ID_W-1:0]  rsp_id,
    output logic [RET_W-1:0] rsp_name,
    output logic             rsp_null,
    output logic [OW-1:0]    outstanding,
    output logic             err_unexpected
);

    state_e            state_q, state_d;
    logic [ID_W-1:0]   call_id_q, call_id_d;
    logic              alive_q, alive_d;
    logic              err_q, err_d;

    logic              call_fire;
    logic              ret_fire;
    logic              tag_pop;
    logic              tag_full;
    logic              tag_empty;
    logic [ID_W-1:0]   tag_head;
    logic [OW-1:0]     tag_count;

    logic              rsp_pop;
    logic              rsp_full;
    logic              rsp_empty;
    logic [RW-1:0]     rsp_count;
    logic [ID_W+RET_W-1:0] rsp_head;

    // alive_q keeps req_ready low while reset is held.
    always_comb begin
        state_d    = state_q;
        call_id_d  = call_id_q;
        alive_d    = 1'b1;
        call_start = 1'b0;
        call_fire  = 1'b0;
        req_ready  = 1'b0;
        unique case (state_q)
            IDLE: begin
                req_ready = alive_q;
                if (req_valid && alive_q) begin
                    call_id_d = req_id;
                    state_d   = ISSUE;
                end
            end
            ISSUE: begin
                call_start = !tag_full;
                call_fire  = call_start && !call_busy;
                req_ready  = call_fire;
                if (call_fire) begin
                    if (req_valid) begin
                        call_id_d = req_id;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
        endcase
    end

    // Backpressure uses the registered full flag; no push/pop bypass.
    assign ret_stall = rsp_full;
    assign ret_fire  = ret_done && !rsp_full;
    assign tag_pop   = ret_fire && !tag_empty;
    assign err_d     = err_q || (ret_fire && tag_empty);
    assign rsp_pop   = rsp_ready && !rsp_empty;

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= IDLE;
            call_id_q <= '0;
            alive_q   <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            call_id_q <= call_id_d;
            alive_q   <= alive_d;
            err_q     <= err_d;
        end
    end

    v4l2_sync_fifo #(
        .WIDTH (ID_W),
        .DEPTH (MAX_OUTSTANDING)
    ) u_tag_fifo (
        .clock     (clock),
        .reset     (reset),
        .push      (call_fire),
        .push_data (call_id_q),
        .pop       (tag_pop),
        .pop_data  (tag_head),
        .full      (tag_full),
        .empty     (tag_empty),
        .count     (tag_count)
    );

    v4l2_sync_fifo #(
        .WIDTH (ID_W + RET_W),
        .DEPTH (RSP_DEPTH)
    ) u_rsp_fifo (
        .clock     (clock),
        .reset     (reset),
        .push      (tag_pop),
        .push_data ({tag_head, ret_data}),
        .pop       (rsp_pop),
        .pop_data  (rsp_head),
        .full      (rsp_full),
        .empty     (rsp_empty),
        .count     (rsp_count)
    );

    assign call_id        = call_id_q;
    assign outstanding    = tag_count;
    assign err_unexpected = err_q;
    assign rsp_valid      = (rsp_count != '0);
    assign rsp_id         = rsp_head[ID_W+RET_W-1:RET_W];
    assign rsp_name       = rsp_head[RET_W-1:0];
    assign rsp_null       = (rsp_name == '0);

endmodule

// File: tb/tb_v4l2_ctrl_name_caller.sv
// Directed bench for v4l2_ctrl_name_caller: call issue, busy hold,
// outstanding window, backpressure, null/spurious returns, reset.
module tb_v4l2_ctrl_name_caller;

    logic        clock;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_id;
    logic        call_start;
    logic        call_busy;
    logic [31:0] call_id;
    logic        ret_done;
    logic        ret_stall;
    logic [63:0] ret_data;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_id;
    logic [63:0] rsp_name;
    logic        rsp_null;
    logic [2:0]  outstanding;
    logic        err_unexpected;

    int errors = 0;
    int checks = 0;

    v4l2_ctrl_name_caller dut (
        .clock          (clock),
        .reset          (reset),
        .req_valid      (req_valid),
        .req_ready      (req_ready),
        .req_id         (req_id),
        .call_start     (call_start),
        .call_busy      (call_busy),
        .call_id        (call_id),
        .ret_done       (ret_done),
        .ret_stall      (ret_stall),
        .ret_data       (ret_data),
        .rsp_valid      (rsp_valid),
        .rsp_ready      (rsp_ready),
        .rsp_id         (rsp_id),
        .rsp_name       (rsp_name),
        .rsp_null       (rsp_null),
        .outstanding    (outstanding),
        .err_unexpected (err_unexpected)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Offers n requests base..base+n-1 for a fixed number of cycles.
    task automatic issue_n(input int n, input logic [31:0] base,
                           input int cycles, output int acc,
                           output int fires);
        int k;
        logic hs;
        k = 0;
        fires = 0;
        for (int c = 0; c < cycles; c++) begin
            req_valid = (k < n);
            req_id    = base + 32'(k);
            #1;
            hs = req_valid && req_ready;
            if (call_start && !call_busy) fires++;
            tick();
            if (hs) k++;
        end
        acc = k;
    endtask

    initial begin
        int acc;
        int fires;
        reset     = 1'b1;
        req_valid = 1'b0;
        req_id    = '0;
        call_busy = 1'b0;
        ret_done  = 1'b0;
        ret_data  = '0;
        rsp_ready = 1'b1;
        tick();
        tick();
        chk("rst_req_ready", 64'(req_ready), 64'd0);
        chk("rst_call_start", 64'(call_start), 64'd0);
        chk("rst_ret_stall", 64'(ret_stall), 64'd0);
        chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
        chk("rst_outstanding", 64'(outstanding), 64'd0);
        chk("rst_err", 64'(err_unexpected), 64'd0);
        reset = 1'b0;
        tick();

        // 1: single call
        req_valid = 1'b1;
        req_id    = 32'h0098_0900;
        #1;
        chk("t1_req_ready", 64'(req_ready), 64'd1);
        tick();
        req_valid = 1'b0;
        #1;
        chk("t1_call_start", 64'(call_start), 64'd1);
        chk("t1_call_id", 64'(call_id), 64'h0098_0900);
        tick();
        chk("t1_outstanding", 64'(outstanding), 64'd1);
        chk("t1_start_low", 64'(call_start), 64'd0);
        tick();
        tick();
        ret_done = 1'b1;
        ret_data = 64'h1000;
        #1;
        chk("t1_ret_stall", 64'(ret_stall), 64'd0);
        tick();
        ret_done = 1'b0;
        #1;
        chk("t1_rsp_valid", 64'(rsp_valid), 64'd1);
        chk("t1_rsp_id", 64'(rsp_id), 64'h0098_0900);
        chk("t1_rsp_name", rsp_name, 64'h1000);
        chk("t1_rsp_null", 64'(rsp_null), 64'd0);
        chk("t1_outst_zero", 64'(outstanding), 64'd0);
        tick();
        chk("t1_rsp_drained", 64'(rsp_valid), 64'd0);

        // 2: busy hold
        req_valid = 1'b1;
        req_id    = 32'h0098_0901;
        call_busy = 1'b1;
        #1;
        tick();
        req_id = 32'h0098_0902;
        for (int i = 0; i < 5; i++) begin
            #1;
            chk("t2_start_held", 64'(call_start), 64'd1);
            chk("t2_id_held", 64'(call_id), 64'h0098_0901);
            chk("t2_req_blocked", 64'(req_ready), 64'd0);
            chk("t2_no_push", 64'(outstanding), 64'd0);
            tick();
        end
        call_busy = 1'b0;
        #1;
        chk("t2_req_ready_fire", 64'(req_ready), 64'd1);
        tick();
        req_valid = 1'b0;
        #1;
        chk("t2_one_push", 64'(outstanding), 64'd1);
        chk("t2_reload_id", 64'(call_id), 64'h0098_0902);
        chk("t2_start_again", 64'(call_start), 64'd1);
        tick();
        chk("t2_two_out", 64'(outstanding), 64'd2);
        chk("t2_idle", 64'(call_start), 64'd0);
        ret_done = 1'b1;
        ret_data = 64'h2000;
        #1;
        tick();
        ret_data = 64'h2001;
        #1;
        chk("t2_rsp0_id", 64'(rsp_id), 64'h0098_0901);
        chk("t2_rsp0_name", rsp_name, 64'h2000);
        tick();
        ret_done = 1'b0;
        #1;
        chk("t2_rsp1_id", 64'(rsp_id), 64'h0098_0902);
        chk("t2_rsp1_name", rsp_name, 64'h2001);
        tick();
        chk("t2_drained", 64'(rsp_valid), 64'd0);
        chk("t2_out_zero", 64'(outstanding), 64'd0);

        // 3: outstanding window
        issue_n(6, 32'h10, 8, acc, fires);
        chk("t3_fires", 64'(fires), 64'd4);
        chk("t3_accepted", 64'(acc), 64'd5);
        chk("t3_outstanding", 64'(outstanding), 64'd4);
        chk("t3_start_gated", 64'(call_start), 64'd0);
        chk("t3_pending_id", 64'(call_id), 64'h14);
        chk("t3_req_blocked", 64'(req_ready), 64'd0);
        ret_done = 1'b1;
        ret_data = 64'h3000;
        #1;
        tick();
        ret_done = 1'b0;
        #1;
        chk("t3_fifth_start", 64'(call_start), 64'd1);
        chk("t3_after_ret", 64'(outstanding), 64'd3);
        chk("t3_rsp_id", 64'(rsp_id), 64'h10);
        chk("t3_rsp_name", rsp_name, 64'h3000);
        tick();
        req_valid = 1'b0;
        #1;
        chk("t3_refill", 64'(outstanding), 64'd4);
        chk("t3_next_id", 64'(call_id), 64'h15);
        ret_done = 1'b1;
        for (int i = 0; i < 5; i++) begin
            ret_data = 64'h3001 + 64'(i);
            #1;
            tick();
            chk("t3_order_id", 64'(rsp_id), 64'h11 + 64'(i));
            chk("t3_order_name", rsp_name, 64'h3001 + 64'(i));
        end
        ret_done = 1'b0;
        #1;
        tick();
        chk("t3_drained", 64'(rsp_valid), 64'd0);
        chk("t3_out_zero", 64'(outstanding), 64'd0);

        // 4: response backpressure
        rsp_ready = 1'b0;
        issue_n(3, 32'h20, 6, acc, fires);
        req_valid = 1'b0;
        chk("t4_outstanding", 64'(outstanding), 64'd3);
        ret_done = 1'b1;
        ret_data = 64'h4000;
        #1;
        chk("t4_stall0", 64'(ret_stall), 64'd0);
        tick();
        ret_data = 64'h4001;
        #1;
        chk("t4_stall1", 64'(ret_stall), 64'd0);
        tick();
        ret_data = 64'h4002;
        for (int i = 0; i < 2; i++) begin
            #1;
            chk("t4_stall_full", 64'(ret_stall), 64'd1);
            chk("t4_head_stable", 64'(rsp_id), 64'h20);
            chk("t4_name_stable", rsp_name, 64'h4000);
            chk("t4_out_one", 64'(outstanding), 64'd1);
            tick();
        end
        rsp_ready = 1'b1;
        #1;
        chk("t4_stall_reg", 64'(ret_stall), 64'd1);
        tick();
        chk("t4_rsp1_id", 64'(rsp_id), 64'h21);
        chk("t4_rsp1_name", rsp_name, 64'h4001);
        chk("t4_unstall", 64'(ret_stall), 64'd0);
        tick();
        ret_done = 1'b0;
        #1;
        chk("t4_rsp2_id", 64'(rsp_id), 64'h22);
        chk("t4_rsp2_name", rsp_name, 64'h4002);
        chk("t4_out_zero", 64'(outstanding), 64'd0);
        tick();
        chk("t4_drained", 64'(rsp_valid), 64'd0);

        // 5: unknown ID and spurious return
        req_valid = 1'b1;
        req_id    = 32'h1234_5678;
        #1;
        tick();
        req_valid = 1'b0;
        #1;
        tick();
        ret_done = 1'b1;
        ret_data = 64'h0;
        #1;
        tick();
        ret_done = 1'b0;
        #1;
        chk("t5_rsp_valid", 64'(rsp_valid), 64'd1);
        chk("t5_rsp_id", 64'(rsp_id), 64'h1234_5678);
        chk("t5_rsp_null", 64'(rsp_null), 64'd1);
        chk("t5_no_err", 64'(err_unexpected), 64'd0);
        tick();
        ret_done = 1'b1;
        ret_data = 64'hdead;
        #1;
        tick();
        ret_done = 1'b0;
        #1;
        chk("t5_err_set", 64'(err_unexpected), 64'd1);
        chk("t5_out_zero", 64'(outstanding), 64'd0);
        chk("t5_no_rsp", 64'(rsp_valid), 64'd0);
        tick();
        tick();
        chk("t5_err_sticky", 64'(err_unexpected), 64'd1);

        // 6: reset mid-flight
        rsp_ready = 1'b0;
        issue_n(4, 32'h30, 7, acc, fires);
        req_valid = 1'b0;
        ret_done  = 1'b1;
        ret_data  = 64'h5000;
        #1;
        tick();
        ret_done = 1'b0;
        #1;
        chk("t6_pre_out", 64'(outstanding), 64'd3);
        chk("t6_pre_rsp", 64'(rsp_valid), 64'd1);
        reset     = 1'b1;
        req_valid = 1'b1;
        #1;
        tick();
        chk("t6_req_ready", 64'(req_ready), 64'd0);
        chk("t6_call_start", 64'(call_start), 64'd0);
        chk("t6_ret_stall", 64'(ret_stall), 64'd0);
        chk("t6_rsp_valid", 64'(rsp_valid), 64'd0);
        chk("t6_outstanding", 64'(outstanding), 64'd0);
        chk("t6_err", 64'(err_unexpected), 64'd0);
        reset     = 1'b0;
        req_valid = 1'b0;
        #1;
        tick();
        chk("t6_ready_back", 64'(req_ready), 64'd1);
        chk("t6_empty", 64'(rsp_valid), 64'd0);
        chk("t6_idle", 64'(call_start), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
